// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV64M shift-add multiplier / restoring divider with pipeline stall.
// Define MDU_EARLY_OUT_EN for 2-cycle exits on divide-by-zero, signed overflow and zero multiplies.
module mdu_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            word_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int H = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op;
  logic wop, neg_q, neg_r, div0, accept, in_w, ws, na, nb, b_zero, early, ge;
  logic [XLEN-1:0] a, b, mp, ea, eb, abs_a, abs_b, rd, qs, rs, sel, fix_res;
  logic [2*XLEN-1:0] prod, mc, ps;
  logic [XLEN:0] rt;
  logic [CW-1:0] cnt;

  function automatic logic [XLEN-1:0] sx(input logic [H-1:0] v);
    return {{H{v[H-1]}}, v};
  endfunction

  // word forms exist only for MUL and DIV/REM; MULH* with word_op run full-width
  assign in_w = word_op & (funct3 == 3'd0 | funct3[2]);
  assign ws = ~funct3[0];
  assign ea = in_w ? {{H{ws & rs1[H-1]}}, rs1[H-1:0]} : rs1;
  assign eb = in_w ? {{H{ws & rs2[H-1]}}, rs2[H-1:0]} : rs2;
  assign accept = start & ~flush & (state == IDLE | state == DONE);

  assign na = (op inside {3'd1, 3'd2, 3'd4, 3'd6}) & a[XLEN-1];
  assign nb = (op inside {3'd1, 3'd4, 3'd6}) & b[XLEN-1];
  assign abs_a = na ? -a : a;
  assign abs_b = nb ? -b : b;
  assign b_zero = b == '0;

  // restoring step: prod holds {remainder, quotient}, mp holds the divisor
  assign rt = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
  assign ge = rt >= {1'b0, mp};
  assign rd = ge ? XLEN'(rt - {1'b0, mp}) : rt[XLEN-1:0];

  assign ps = neg_q ? -prod : prod;
  assign qs = neg_q & ~div0 ? -prod[XLEN-1:0] : prod[XLEN-1:0];
  assign rs = neg_r ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
  assign sel = op == 3'd0 ? ps[XLEN-1:0] : ~op[2] ? ps[2*XLEN-1:XLEN] : op[1] ? rs : qs;
  assign fix_res = wop ? sx(sel[H-1:0]) : sel;

`ifdef MDU_EARLY_OUT_EN
  logic ovf;
  logic [XLEN-1:0] min_v, er;
  assign min_v = wop ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign ovf = op[2] & ~op[0] & a == min_v & b == '1;
  assign early = op[2] ? b_zero | ovf : a == '0 | b_zero;
  assign er = ~op[2] ? '0 : op[1] ? (b_zero ? a : '0) : b_zero ? '1 : a;
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (state == IDLE || state == DONE) state_nx = start ? PREP : IDLE;
    else if (state == PREP) state_nx = early ? DONE : CALC;
    else if (state == CALC) state_nx = cnt == CW'(1) ? FIX : CALC;
    else if (state == FIX) state_nx = DONE;
  end

  always_comb begin
    busy = state inside {PREP, CALC, FIX};
    stall = busy | (start & state == IDLE);
    done = state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= '0;
      wop <= 1'b0;
      a <= '0;
      b <= '0;
      mp <= '0;
      mc <= '0;
      prod <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        op <= funct3;
        wop <= in_w;
        a <= ea;
        b <= eb;
      end
      if (state == PREP) begin
        neg_q <= na ^ nb;
        neg_r <= na;
        div0 <= b_zero;
        cnt <= wop ? CW'(H) : CW'(XLEN);
        mc <= {{XLEN{1'b0}}, abs_a};
        mp <= abs_b;
        prod <= op[2] ? {{XLEN{1'b0}}, wop ? abs_a << H : abs_a} : '0;
`ifdef MDU_EARLY_OUT_EN
        if (early & ~flush) result <= wop ? sx(er[H-1:0]) : er;
`endif
      end
      if (state == CALC) begin
        cnt <= cnt - CW'(1);
        prod <= op[2] ? {rd, prod[XLEN-2:0], ge} : prod + (mp[0] ? mc : '0);
        mc <= mc << 1;
        mp <= op[2] ? mp : mp >> 1;
      end
      if (state == FIX & ~flush) result <= fix_res;
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vector table plus flush, back-to-back and reset sequences.
module tb_mdu_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, word_op = 1'b0, flush = 1'b0;
  logic [2:0] funct3 = 3'd0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic busy, stall, done;
  logic [63:0] result;
  int n_chk = 0, n_fail = 0;
`ifdef MDU_EARLY_OUT_EN
  localparam int LE = 2, LEW = 2;
`else
  localparam int LE = 67, LEW = 35;
`endif
  typedef struct {
    logic [2:0]  f;
    logic        w;
    logic [63:0] x, y, exp;
    int          lat;
  } vec_t;
  vec_t v[21];

  mdu_sequencer #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .word_op(word_op),
    .rs1(rs1), .rs2(rs2), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] x, input logic [63:0] y,
                        output int lat, output bit st_ok);
    funct3 = f;
    word_op = w;
    rs1 = x;
    rs2 = y;
    start = 1'b1;
    #1 st_ok = stall === 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      st_ok = st_ok & (stall === 1'b1);
      @(posedge clk); #1;
      lat++;
    end
    st_ok = st_ok & (stall === 1'b0);
  endtask

  initial begin
    int lat, cnt;
    bit ok;
    v[0]  = '{3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 67};
    v[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 67};
    v[2]  = '{3'd4, 1'b1, 64'h1_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 35};
    v[3]  = '{3'd4, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LE};
    v[4]  = '{3'd6, 1'b0, 64'd100, 64'd0, 64'd100, LE};
    v[5]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, LE};
    v[6]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LE};
    v[7]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    v[8]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    v[9]  = '{3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 67};
    v[10] = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67};
    v[11] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    v[12] = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 67};
    v[13] = '{3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35};
    v[14] = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35};
    v[15] = '{3'd0, 1'b0, 64'd0, 64'd5, 64'd0, LE};
    v[16] = '{3'd7, 1'b1, 64'h1234_5678_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, LEW};
    v[17] = '{3'd1, 1'b1, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    v[18] = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, LEW};
    v[19] = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LE};
    v[20] = '{3'd3, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 67};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_result", result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      run_op(v[i].f, v[i].w, v[i].x, v[i].y, lat, ok);
      chk($sformatf("v%0d_result", i), result, v[i].exp);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v[i].lat));
      chk($sformatf("v%0d_stall", i), 64'(ok), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // flush at cycle 20 of a REMU with a competing start
    funct3 = 3'd7; word_op = 1'b0; rs1 = 64'd100; rs2 = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1; start = 1'b1; funct3 = 3'd0; rs1 = 64'd5; rs2 = 64'd5;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_idle", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_result_hold", result, v[20].exp);
    cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    chk("flush_no_done", 64'(cnt), 64'd0);
    chk("flush_start_ignored", 64'(busy), 64'd0);
    chk("flush_result_final", result, v[20].exp);

    // back-to-back: start in DONE, then a stray start in CALC
    run_op(3'd5, 1'b0, 64'd1000, 64'd10, lat, ok);
    chk("b2b_first_result", result, 64'd100);
    chk("b2b_first_latency", 64'(lat), 64'd67);
    funct3 = 3'd0; rs1 = 64'd6; rs2 = 64'd7; start = 1'b1;
    #1 chk("b2b_stall_in_done", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 10) begin
        start = 1'b1; funct3 = 3'd5; rs1 = 64'd99; rs2 = 64'd3;
      end else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("b2b_second_latency", 64'(lat), 64'd67);
    chk("b2b_second_result", result, 64'd42);
    @(posedge clk); #1;

    // asynchronous reset in CALC
    funct3 = 3'd4; rs1 = 64'd50; rs2 = 64'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_result", result, 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    #2 rst_n = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    chk("arst_no_done", 64'(cnt), 64'd0);
    chk("arst_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer for the RV64 M extension, sitting beside the main ALU in the EX stage. It accepts one MUL/DIV/REM operation at a time, runs a shift-add multiplier or a restoring divider over multiple cycles, and holds the pipeline with `stall` until the result is ready. It also handles the RISC-V special cases: divide-by-zero, signed overflow and word (`*W`) variants.

## Interface
Parameters:
- `XLEN`, default 64: operand and result width. Must be even; word ops use the `XLEN/2` low bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only in IDLE or DONE.
- `funct3`  in  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `word_op`  in  1  `*W` variant; valid with funct3 0 and 4–7 only.
- `rs1`  in  XLEN  dividend / multiplicand.
- `rs2`  in  XLEN  divisor / multiplier.
- `flush`  in  1  abort the in-flight operation.
- `busy`  out  1  high in PREP, CALC and FIX.
- `stall`  out  1  pipeline hold request (see Timing).
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  XLEN  final value; held until the next accepted `start`.

## Operation
- **States:** IDLE, PREP, CALC, FIX, DONE. Reset puts the block in IDLE with `busy`=0, `done`=0, `result`=0 and the iteration counter at 0.
- **IDLE/DONE + `start`:**
  - Latch `funct3`, `word_op`, `rs1`, `rs2`.
  - For word ops, sign- or zero-extend the low halves per signedness.
  - Go to PREP.
- **PREP (1 cycle):**
  - Take absolute values of the signed operands.
  - Record the result sign: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Load the counter with N = XLEN, or XLEN/2 if `word_op`.
- **CALC (N cycles):** one iteration per cycle, counter decrements, leave when it reaches 0.
  - Multiply: shift-add into a 2·XLEN product register.
  - Divide: restoring shift-subtract into quotient and remainder registers.
- **FIX (1 cycle):**
  - Apply the sign correction.
  - Select the output: MUL takes the low half; MULH/MULHSU/MULHU take the high half; DIV takes the quotient; REM takes the remainder.
  - For `word_op`, sign-extend bit XLEN/2−1 of the selected value.
- **DONE (1 cycle):** `done`=1. Go to PREP if `start`, otherwise IDLE.
- **Divide by zero:** quotient = all ones; remainder = dividend. The sign correction of the quotient is suppressed.
- **Signed overflow** (most-negative / −1): quotient = dividend; remainder = 0.
- **`start` during PREP, CALC or FIX:** ignored. No queuing.
- **`flush`:**
  - Returns any state to IDLE on the next edge. `done` is not pulsed and `result` is unchanged.
  - `flush` wins over a simultaneous `start`.
- **Unsupported `word_op` with funct3 1–3:** executes as the non-word op.

## Timing
- Start-sampling edge = cycle 0. PREP is cycle 1, CALC is cycles 2..N+1, FIX is N+2, DONE is N+3.
- Latency is N+3 cycles: 67 for 64-bit ops, 35 for word ops at XLEN=64.
- `stall` is combinational: `start` while in IDLE, OR state ∈ {PREP, CALC, FIX}. `stall` is low in DONE so the pipeline advances and captures `result` on that edge.
- Back-to-back ops: `start` in DONE is accepted, so there is no idle bubble between operations.
- Asynchronous reset mid-operation clears the state immediately. `done` never pulses for the aborted op.

## Configuration
- `MDU_EARLY_OUT_EN` defined:
  - Divide-by-zero and signed overflow are detected in PREP. The block goes PREP→DONE directly, with `result` written in PREP, giving a latency of 2 cycles.
  - Multiply with either operand 0 also early-outs with result 0.
- Not defined:
  - Every op takes the full N+3 cycles.
  - Special-case values are still produced correctly by FIX, using flags captured in PREP.

## Test plan
- **MUL −3 × 7, XLEN=64:** `done` at cycle 67 with `result`=0xFFFF_FFFF_FFFF_FFEB; `stall` high in cycles 0–66 and low in cycle 67.
- **MULHU 0xFFFF_FFFF_FFFF_FFFF × 2:** `result`=1. **DIVW 0x1_8000_0000 / 2:** `result`=0xFFFF_FFFF_C000_0000, `done` at cycle 35.
- **DIV 100 / 0:**
  - `result`=0xFFFF_FFFF_FFFF_FFFF.
  - REM 100 / 0 → 100.
  - `done` at cycle 2 with `MDU_EARLY_OUT_EN`, cycle 67 without it.
- **DIV 0x8000_0000_0000_0000 / −1:** quotient 0x8000_0000_0000_0000. REM of the same operands → 0.
- **`flush` at cycle 20 of REMU, with `start` asserted in the same cycle:** IDLE next cycle, no `done`, `result` holds the previous value, the new `start` is not taken.
- **Back-to-back:**
  - Second `start` asserted in DONE: the next `done` arrives N+3 cycles later.
  - `start` pulsed while in CALC: ignored.
  - `rst_n` dropped in CALC: `busy`=0 and `result`=0 immediately.
